// File: rtl/cacheline_burst_adaptor.sv
// Converts one cache-line read/write into a fixed burst of beats and returns a one-cycle response.
// Optional watchdog on stalled bursts: define CACHELINE_BURST_TIMEOUT_EN.
module cacheline_burst_adaptor #(
    parameter int BEAT_WIDTH     = 64,
    parameter int BEATS          = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int LINE_WIDTH     = BEAT_WIDTH * BEATS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] line_addr_i,
    input  logic                  line_read_i,
    input  logic                  line_write_i,
    input  logic [LINE_WIDTH-1:0] line_wdata_i,
    output logic [LINE_WIDTH-1:0] line_rdata_o,
    output logic                  line_resp_o,
    output logic [ADDR_WIDTH-1:0] burst_addr_o,
    output logic                  burst_read_o,
    output logic                  burst_write_o,
    output logic [BEAT_WIDTH-1:0] burst_wdata_o,
    input  logic [BEAT_WIDTH-1:0] burst_rdata_i,
    input  logic                  burst_resp_i,
    output logic                  err_o
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFFS  = $clog2(LINE_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((64'd1 << OFFS) - 64'd1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] line_q;
    logic [LINE_WIDTH-1:0] line_rdata_q;
    logic [LINE_WIDTH-1:0] rd_line;
    logic                  in_burst, beat_ok, last_beat, timeout;

    assign in_burst  = (state_q == RD_BURST) || (state_q == WR_BURST);
    assign beat_ok   = in_burst && burst_resp_i;
    assign last_beat = beat_ok && (cnt_q == LAST);

`ifdef CACHELINE_BURST_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q;

    // Counts consecutive beat-less cycles; any accepted beat or leaving the burst clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (in_burst && !burst_resp_i && !timeout) begin
            wd_q <= wd_q + 1'b1;
        end else begin
            wd_q <= '0;
        end
    end

    assign timeout = in_burst && !burst_resp_i && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // Line buffer with the incoming read beat merged into its slot.
    always_comb begin
        rd_line = line_q;
        rd_line[cnt_q*BEAT_WIDTH +: BEAT_WIDTH] = burst_rdata_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (line_read_i)       state_d = RD_BURST;
                else if (line_write_i) state_d = WR_BURST;
            end
            RD_BURST, WR_BURST: begin
                if (last_beat)    state_d = DONE;
                else if (timeout) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        line_resp_o   = (state_q == DONE);
        burst_read_o  = (state_q == RD_BURST);
        burst_write_o = (state_q == WR_BURST);
        burst_addr_o  = (state_q == IDLE) ? '0 : addr_q;
        burst_wdata_o = '0;
        if (state_q == WR_BURST) burst_wdata_o = line_q[cnt_q*BEAT_WIDTH +: BEAT_WIDTH];
        err_o         = timeout;
        line_rdata_o  = line_rdata_q;
    end

    // Request side is sampled only on IDLE exit; later changes on it are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            addr_q       <= '0;
            line_q       <= '0;
            line_rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (line_read_i || line_write_i) begin
                        addr_q <= line_addr_i & ALIGN_MASK;
                        cnt_q  <= '0;
                    end
                    if (!line_read_i && line_write_i) line_q <= line_wdata_i;
                end
                RD_BURST: begin
                    if (beat_ok) begin
                        line_q <= rd_line;
                        if (!last_beat) cnt_q <= cnt_q + 1'b1;
                    end
                    if (last_beat) line_rdata_q <= rd_line;
                end
                WR_BURST: begin
                    if (beat_ok && !last_beat) cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Directed plus randomized bench for cacheline_burst_adaptor; expected beats and lines come
// from a simple line/beat model held in the bench.
module tb_cacheline_burst_adaptor;
    localparam int BW = 64;
    localparam int NB = 4;
    localparam int LW = BW * NB;
    localparam int AW = 32;
`ifdef CACHELINE_BURST_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] line_addr_i;
    logic          line_read_i;
    logic          line_write_i;
    logic [LW-1:0] line_wdata_i;
    logic [LW-1:0] line_rdata_o;
    logic          line_resp_o;
    logic [AW-1:0] burst_addr_o;
    logic          burst_read_o;
    logic          burst_write_o;
    logic [BW-1:0] burst_wdata_o;
    logic [BW-1:0] burst_rdata_i;
    logic          burst_resp_i;
    logic          err_o;

    cacheline_burst_adaptor #(
        .BEAT_WIDTH(BW), .BEATS(NB), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .line_addr_i(line_addr_i), .line_read_i(line_read_i), .line_write_i(line_write_i),
        .line_wdata_i(line_wdata_i), .line_rdata_o(line_rdata_o), .line_resp_o(line_resp_o),
        .burst_addr_o(burst_addr_o), .burst_read_o(burst_read_o), .burst_write_o(burst_write_o),
        .burst_wdata_o(burst_wdata_o), .burst_rdata_i(burst_rdata_i), .burst_resp_i(burst_resp_i),
        .err_o(err_o)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            vectors;
    int            miscompares;
    logic [BW-1:0] exp_q[$];
    logic [LW-1:0] last_line;

    task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_resp"}, line_resp_o, 1'b0);
        check({tag, "_rd"}, burst_read_o, 1'b0);
        check({tag, "_wr"}, burst_write_o, 1'b0);
        check({tag, "_addr"}, burst_addr_o, '0);
        check({tag, "_wdata"}, burst_wdata_o, '0);
        check({tag, "_err"}, err_o, 1'b0);
        check({tag, "_rdata"}, line_rdata_o, last_line);
    endtask

    // One line transaction. gaps[k*4+:4] = stall cycles before beat k; b2b drives the
    // request at the current negedge instead of waiting one.
    task automatic txn(input bit is_rd, input bit both, input logic [AW-1:0] addr,
                       input logic [LW-1:0] wline, input logic [15:0] gaps,
                       input bit fixed_beats, input bit b2b);
        logic [LW-1:0] rline;
        logic [BW-1:0] beat;
        logic [AW-1:0] a_exp;
        int k;
        int gap;
        a_exp = addr - (addr % 32);
        rline = '0;
        if (!is_rd) for (int i = 0; i < NB; i++) exp_q.push_back(wline[i*BW +: BW]);
        if (!b2b) @(negedge clk);
        line_read_i  = is_rd;
        line_write_i = !is_rd || both;
        line_addr_i  = addr;
        line_wdata_i = wline;
        if (both) $display("protocol warning: read and write requested together");
        k   = 0;
        gap = int'(gaps[3:0]);
        while (k < NB) begin
            @(negedge clk);
            check("burst_read", burst_read_o, is_rd);
            check("burst_write", burst_write_o, !is_rd);
            check("burst_addr", burst_addr_o, a_exp);
            check("resp_mid_burst", line_resp_o, 1'b0);
            check("err_mid_burst", err_o, 1'b0);
            if (!is_rd) check("burst_wdata", burst_wdata_o, exp_q[0]);
            else        check("burst_wdata_rd", burst_wdata_o, '0);
            line_addr_i  = $urandom;
            line_wdata_i = {8{$urandom}};
            if (gap > 0) begin
                gap--;
                burst_resp_i  = 1'b0;
                burst_rdata_i = {$urandom, $urandom};
            end else begin
                beat = fixed_beats ? {16{4'(k + 1)}} : {$urandom, $urandom};
                burst_resp_i  = 1'b1;
                burst_rdata_i = beat;
                rline[k*BW +: BW] = beat;
                if (!is_rd) beat = exp_q.pop_front();
                k++;
                if (k < NB) gap = int'(gaps[k*4 +: 4]);
            end
        end
        @(negedge clk);
        if (is_rd) last_line = rline;
        check("line_resp", line_resp_o, 1'b1);
        check("done_rd", burst_read_o, 1'b0);
        check("done_wr", burst_write_o, 1'b0);
        check("line_rdata_done", line_rdata_o, last_line);
        burst_resp_i  = 1'b0;
        burst_rdata_i = {$urandom, $urandom};
        line_read_i   = 1'b0;
        line_write_i  = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_done");
    endtask

    initial begin
        logic [LW-1:0] wl;
        logic [15:0]   g;
        vectors = 0; miscompares = 0; last_line = '0;
        rst_n = 1'b0;
        line_addr_i = '0; line_read_i = 1'b0; line_write_i = 1'b0; line_wdata_i = '0;
        burst_rdata_i = '0; burst_resp_i = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;

        // Read, back-to-back beats 0x1111.., 0x2222.., ...
        txn(1'b1, 1'b0, 32'h0000_1234, '0, 16'h0000, 1'b1, 1'b0);
        check("read_line_pattern", last_line,
              {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});

        // Write with stalls: resp on cycles 2, 5, 6, 9
        wl = {8{$urandom}};
        txn(1'b0, 1'b0, 32'h0000_2F00, wl, 16'h2021, 1'b0, 1'b0);

        // Both requests high: read only
        txn(1'b1, 1'b1, 32'hABCD_EF7F, {8{$urandom}}, 16'h0100, 1'b0, 1'b0);

        // Reset while beat 2 of a read is in flight
        @(negedge clk);
        line_read_i = 1'b1; line_addr_i = 32'h0000_4444;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            burst_resp_i = 1'b1; burst_rdata_i = {$urandom, $urandom};
        end
        #2 rst_n = 1'b0;
        #1;
        last_line = '0;
        check_idle_outputs("async_reset");
        line_read_i = 1'b0; burst_resp_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_reset");
        txn(1'b1, 1'b0, 32'h0000_5A5A, '0, 16'h0102, 1'b0, 1'b0);

        // Read then write issued the cycle after the IDLE return
        txn(1'b1, 1'b0, 32'h1000_0010, '0, 16'h0000, 1'b0, 1'b0);
        txn(1'b0, 1'b0, 32'h2000_003F, {8{$urandom}}, 16'h0000, 1'b0, 1'b1);

        // Randomized transactions
        for (int t = 0; t < 24; t++) begin
            g = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            txn(1'($urandom_range(0, 1)), 1'b0, $urandom, {8{$urandom}}, g, 1'b0,
                1'($urandom_range(0, 1)));
        end

`ifdef CACHELINE_BURST_TIMEOUT_EN
        // Read with no beats: watchdog fires on cycle 8 of RD_BURST
        @(negedge clk);
        line_read_i = 1'b1; line_addr_i = 32'h0000_8000;
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            check("wd_err", err_o, (c == TO));
            check("wd_resp", line_resp_o, 1'b0);
            check("wd_rd", burst_read_o, 1'b1);
        end
        line_read_i = 1'b0;
        @(negedge clk);
        check_idle_outputs("wd_after");
        txn(1'b1, 1'b0, 32'h0000_9000, '0, 16'h1111, 1'b0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
